// File: rtl/transposer_pkg.sv
// Shared types for the streaming tile transposer: element format, bank
// lifecycle states and the per-tile output mode.
package transposer_pkg;

    localparam int unsigned IL = 4;
    localparam int unsigned FL = 16;
    localparam int unsigned W  = IL + FL;

    typedef logic signed [W-1:0] elem_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    typedef enum logic {
        XPOSE = 1'b0,
        PASS  = 1'b1
    } xpose_mode_t;

endpackage

// File: rtl/transpose_bank.sv
// One N x N tile buffer: whole-row writes, and a read mux that returns
// either a column (transpose) or a row (passthrough) selected by rd_idx_i.
module transpose_bank
    import transposer_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned EW = 20
) (
    input  logic                   clk,
    input  logic                   we_i,
    input  logic [$clog2(N)-1:0]   wr_row_i,
    input  logic [N*EW-1:0]        wr_data_i,
    input  xpose_mode_t            mode_i,
    input  logic [$clog2(N)-1:0]   rd_idx_i,
    output logic [N*EW-1:0]        rd_data_o
);

    // Contents are deliberately not reset; bank state in the top marks validity.
    logic [EW-1:0] mem_q [N][N];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned c = 0; c < N; c++) begin
                mem_q[wr_row_i][c] <= wr_data_i[c*EW +: EW];
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (mode_i == XPOSE) begin
                rd_data_o[i*EW +: EW] = mem_q[i][rd_idx_i];
            end else begin
                rd_data_o[i*EW +: EW] = mem_q[rd_idx_i][i];
            end
        end
    end

endmodule

// File: rtl/stream_transposer.sv
// Double-buffered streaming N x N tile transposer with valid/ready on both
// sides; one bank fills while the other drains.
module stream_transposer
    import transposer_pkg::*;
#(
    parameter int unsigned IL = 4,
    parameter int unsigned FL = 16,
    parameter int unsigned N  = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_mode,
    input  logic [N*(IL+FL)-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*(IL+FL)-1:0]   out_data,
    output logic                   out_last,
    output logic                   busy
);

    localparam int unsigned EW = IL + FL;
    localparam int unsigned RW = $clog2(N);
    localparam logic [RW-1:0] LAST = RW'(N - 1);

    bank_state_t  state_q [2];
    bank_state_t  state_d [2];
    xpose_mode_t  mode_q  [2];
    xpose_mode_t  mode_d  [2];
    logic         wr_bank_q, wr_bank_d;
    logic         rd_bank_q, rd_bank_d;
    logic [RW-1:0] wr_row_q, wr_row_d;
    logic [RW-1:0] rd_idx_q, rd_idx_d;

    logic          in_fire;
    logic          out_fire;
    logic [N*EW-1:0] rd_data [2];

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < 2; b++) begin
                state_q[b] <= EMPTY;
                mode_q[b]  <= XPOSE;
            end
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_row_q  <= '0;
            rd_idx_q  <= '0;
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                mode_q[b]  <= mode_d[b];
            end
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_row_q  <= wr_row_d;
            rd_idx_q  <= rd_idx_d;
        end
    end

    // Fill and drain never target the same bank in one cycle: a write needs
    // a non-FULL bank and a read needs a FULL one.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_row_d  = wr_row_q;
        rd_idx_d  = rd_idx_q;

        if (in_fire) begin
            if (state_q[wr_bank_q] == EMPTY) begin
                mode_d[wr_bank_q] = xpose_mode_t'(in_mode);
            end
            if (wr_row_q == LAST) begin
                state_d[wr_bank_q] = FULL;
                wr_row_d           = '0;
                wr_bank_d          = !wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_row_d           = wr_row_q + RW'(1);
            end
        end

        if (out_fire) begin
            if (rd_idx_q == LAST) begin
                state_d[rd_bank_q] = EMPTY;
                rd_idx_d           = '0;
                rd_bank_d          = !rd_bank_q;
            end else begin
                rd_idx_d           = rd_idx_q + RW'(1);
            end
        end
    end

    always_comb begin
        in_ready  = (state_q[wr_bank_q] != FULL);
        out_valid = (state_q[rd_bank_q] == FULL);
        out_data  = out_valid ? rd_data[rd_bank_q] : '0;
        out_last  = out_valid && (rd_idx_q == LAST);
        busy      = (state_q[0] != EMPTY) || (state_q[1] != EMPTY);
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        transpose_bank #(
            .N  (N),
            .EW (EW)
        ) u_bank (
            .clk       (clk),
            .we_i      (in_fire && (wr_bank_q == 1'(b))),
            .wr_row_i  (wr_row_q),
            .wr_data_i (in_data),
            .mode_i    (mode_q[b]),
            .rd_idx_i  (rd_idx_q),
            .rd_data_o (rd_data[b])
        );
    end

endmodule

// File: tb/tb_stream_transposer.sv
// Self-checking bench for stream_transposer: a tile-level queue model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_stream_transposer;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 20;
    localparam int unsigned BW = N * W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic          in_mode;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          out_last;
    logic          busy;

    stream_transposer #(
        .IL (4),
        .FL (16),
        .N  (N)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int stalls = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int a, input int b, input int c, input int d);
        logic [W-1:0] ea, eb, ec, ed;
        ea = W'(a); eb = W'(b); ec = W'(c); ed = W'(d);
        return {ed, ec, eb, ea};
    endfunction

    // Tile-level model: whole tiles are turned into expected beats at once.
    logic [BW-1:0] exp_d[$];
    bit            exp_l[$];
    int            pending = 0;
    int            partial = 0;
    bit            cur_mode;
    logic [W-1:0]  rows [N][N];

    logic [BW-1:0] obs_d[$];
    bit            obs_l[$];
    int            obs_t[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            exp_d.delete(); exp_l.delete();
            pending = 0; partial = 0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_out_data", out_data, 0);
        end else begin
            chk("in_ready", in_ready, pending < 2);
            chk("out_valid", out_valid, pending > 0);
            chk("busy", busy, (pending > 0) || (partial > 0));
            if (pending > 0 && exp_d.size() > 0) begin
                chk("out_data", out_data, exp_d[0]);
                chk("out_last", out_last, exp_l[0]);
            end else begin
                chk("idle_out_data", out_data, 0);
                chk("idle_out_last", out_last, 0);
            end
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_l.push_back(out_last);
                obs_t.push_back(cyc);
            end
            if (out_ready && pending > 0) begin
                if (exp_l[0]) pending--;
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
            if (in_valid && pending < 2) begin
                if (partial == 0) cur_mode = in_mode;
                for (int c = 0; c < N; c++) rows[partial][c] = in_data[c*W +: W];
                partial++;
                if (partial == N) begin
                    for (int k = 0; k < N; k++) begin
                        logic [BW-1:0] beat;
                        for (int i = 0; i < N; i++)
                            beat[i*W +: W] = cur_mode ? rows[k][i] : rows[i][k];
                        exp_d.push_back(beat);
                        exp_l.push_back(k == N - 1);
                    end
                    pending++;
                    partial = 0;
                end
            end
        end
    end

    task automatic send_row(input bit m, input logic [BW-1:0] d);
        bit acc;
        int waitc;
        in_valid = 1'b1; in_mode = m; in_data = d; waitc = 0;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1;
            if (!acc) begin stalls++; waitc++; end
        end while (!acc && waitc < 100);
        if (!acc) begin
            n_err++;
            $display("FAIL send_row_timeout: in_ready 0 expected 1");
        end
    endtask

    task automatic send_tile(input bit m, input int base);
        for (int r = 0; r < N; r++)
            send_row(m, pk(base + 4*r + 1, base + 4*r + 2, base + 4*r + 3, base + 4*r + 4));
    endtask

    task automatic wait_obs(input int n);
        int c = 0;
        while (obs_d.size() < n && c < 200) begin
            @(posedge clk); #1; c++;
        end
        chk("drain_count", obs_d.size(), n);
    endtask

    task automatic clr_obs();
        obs_d.delete(); obs_l.delete(); obs_t.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_out_last", out_last, 0);

        // Single tile, transpose
        clr_obs(); out_ready = 1'b1;
        send_tile(0, 0);
        chk("latency_out_valid", out_valid, 1);
        in_valid = 1'b0;
        wait_obs(4);
        chk("t1_beat0", obs_d[0], pk(1, 5, 9, 13));
        chk("t1_beat1", obs_d[1], pk(2, 6, 10, 14));
        chk("t1_beat2", obs_d[2], pk(3, 7, 11, 15));
        chk("t1_beat3", obs_d[3], pk(4, 8, 12, 16));
        chk("t1_last0", obs_l[0], 0);
        chk("t1_last3", obs_l[3], 1);

        // Single tile, passthrough
        clr_obs();
        send_tile(1, 0);
        in_valid = 1'b0;
        wait_obs(4);
        chk("t2_beat0", obs_d[0], pk(1, 2, 3, 4));
        chk("t2_beat3", obs_d[3], pk(13, 14, 15, 16));
        chk("t2_last3", obs_l[3], 1);

        // Back-to-back, three tiles
        clr_obs(); stalls = 0;
        send_tile(0, 100);
        send_tile(0, 200);
        send_tile(0, 300);
        in_valid = 1'b0;
        wait_obs(12);
        chk("b2b_stalls", stalls, 0);
        chk("b2b_no_gaps", obs_t[11] - obs_t[0], 11);
        chk("b2b_t1_beat0", obs_d[4], pk(201, 205, 209, 213));
        chk("b2b_t2_beat3", obs_d[11], pk(304, 308, 312, 316));

        // Backpressure: two tiles loaded with out_ready low
        clr_obs(); out_ready = 1'b0;
        send_tile(0, 400);
        send_tile(1, 500);
        in_valid = 1'b0;
        chk("bp_in_ready_low", in_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data_stable", out_data, pk(401, 405, 409, 413));
        end
        out_ready = 1'b1;
        wait_obs(8);
        chk("bp_t0_beat0", obs_d[0], pk(401, 405, 409, 413));
        chk("bp_t1_beat0", obs_d[4], pk(501, 502, 503, 504));
        chk("bp_t1_last", obs_l[7], 1);

        // Mixed modes with in_mode toggling mid-tile, negative values
        clr_obs();
        send_row(0, pk(-1, 2, -3, 4));
        send_row(1, pk(5, -6, 7, -8));
        send_row(1, pk(9, 10, -11, 12));
        send_row(0, pk(-524288, 524287, 0, -1));
        send_row(1, pk(-7, -8, -9, -10));
        send_row(0, pk(21, 22, 23, 24));
        send_row(0, pk(31, 32, 33, 34));
        send_row(1, pk(41, 42, 43, 44));
        in_valid = 1'b0;
        wait_obs(8);
        chk("mix_a_beat0", obs_d[0], pk(-1, 5, 9, -524288));
        chk("mix_a_beat3", obs_d[3], pk(4, -8, 12, -1));
        chk("mix_a_all_ones", obs_d[3][3*W +: W], 80'hFFFFF);
        chk("mix_b_beat0", obs_d[4], pk(-7, -8, -9, -10));
        chk("mix_b_beat2", obs_d[6], pk(31, 32, 33, 34));

        // Asynchronous reset mid-tile
        clr_obs();
        send_row(0, pk(91, 92, 93, 94));
        send_row(0, pk(95, 96, 97, 98));
        in_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
        chk("post_rst_in_ready", in_ready, 1);
        send_tile(0, 600);
        in_valid = 1'b0;
        wait_obs(4);
        chk("post_rst_beat0", obs_d[0], pk(601, 605, 609, 613));
        chk("post_rst_beat3", obs_d[3], pk(604, 608, 612, 616));
        chk("post_rst_last", obs_l[3], 1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
